// File: rtl/pipe_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready stage between N requesters, grant held per packet.
// Latency: one cycle from accept (i_vld[k] & o_rdy[k]) to the beat appearing on o_data.
// Backpressure: with o_vld=1 and i_rdy=0 every o_rdy is low and all outputs and arbitration state hold.
module pipe_rr_arb #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int IDXW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N*WIDTH-1:0]   i_data,
    input  logic [N-1:0]         i_last,
    input  logic [N-1:0]         i_vld,
    output logic [N-1:0]         o_rdy,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_last,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [IDXW-1:0]      o_src
);

    // One extra bit so ptr + offset (at most 2N-1) never overflows before the wrap.
    localparam int CW = IDXW + 1;
    localparam logic [IDXW-1:0] PTR_RST = IDXW'(N - 1);

    // ST_ARB: free to pick a new requester; ST_LOCK: mid-packet, grant pinned to lock_idx_q.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [IDXW-1:0] lock_idx_q;
    logic [IDXW-1:0] lock_idx_d;

    logic [IDXW-1:0] rr_idx;
    logic            rr_found;
    logic [CW-1:0]   cand_w;
    logic [IDXW-1:0] cand_idx;

    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;
    logic            space;
    logic            accept;

    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_vld;

    // The output register can take a beat when it is empty or being drained this cycle.
    assign space  = ~o_vld | i_rdy;
    assign accept = gnt_vld & space & sel_vld;

    // Round-robin search: first requesting index after ptr, wrapping mod N.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand_w   = '0;
        cand_idx = '0;
        for (int off = 1; off <= N; off++) begin
            cand_w = {1'b0, ptr_q} + CW'(off);
            if (cand_w >= CW'(N)) begin
                cand_w = cand_w - CW'(N);
            end
            cand_idx = cand_w[IDXW-1:0];
            if (!rr_found && i_vld[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // Arbitration state register: lock flag, lock owner and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_ARB;
            ptr_q      <= PTR_RST;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Next state: a non-last beat locks onto its source, a last beat unlocks and demotes it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (sel_last) begin
                state_d = ST_ARB;
                ptr_d   = gnt_idx;
            end else begin
                state_d    = ST_LOCK;
                lock_idx_d = gnt_idx;
            end
        end
    end

    // Grant outputs: locked owner wins unconditionally, otherwise the round-robin pick.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        o_rdy   = '0;
        if (state_q == ST_LOCK) begin
            gnt_idx = lock_idx_q;
            gnt_vld = 1'b1;
        end else begin
            gnt_idx = rr_idx;
            gnt_vld = rr_found;
        end
        for (int k = 0; k < N; k++) begin
            o_rdy[k] = gnt_vld && space && (gnt_idx == IDXW'(k));
        end
    end

    // Steer the granted requester's beat toward the output register.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_vld  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == IDXW'(k)) begin
                sel_data = i_data[k*WIDTH +: WIDTH];
                sel_last = i_last[k];
                sel_vld  = i_vld[k];
            end
        end
    end

    // Output register: load on accept, drop valid on a bare downstream take, otherwise hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_last <= 1'b0;
            o_src  <= '0;
        end else if (accept) begin
            o_vld  <= 1'b1;
            o_data <= sel_data;
            o_last <= sel_last;
            o_src  <= gnt_idx;
        end else if (i_rdy) begin
            o_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_rr_arb.sv
// Randomized and directed bench for pipe_rr_arb against a packet-level round-robin model.
// Latency: checks o_rdy mid-cycle and registered outputs one cycle after each accept.
// Backpressure: i_rdy is driven both in fixed stall windows and randomly.
module tb_pipe_rr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           i_clk = 1'b0;
    logic           i_reset;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic [N-1:0]   i_vld;
    logic [N-1:0]   o_rdy;
    logic [W-1:0]   o_data;
    logic           o_last;
    logic           o_vld;
    logic           i_rdy;
    logic [1:0]     o_src;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the output register should hold and who owns the pipe.
    int         m_ptr;
    int         m_locked;
    int         m_lock;
    logic       m_vld;
    logic [7:0] m_data;
    logic       m_last;
    int         m_src;

    logic [N-1:0] seen_rdy;

    pipe_rr_arb #(.WIDTH(W), .N(N)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_src   (o_src)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = N - 1;
        m_locked = 0;
        m_lock   = 0;
        m_vld    = 1'b0;
        m_data   = 8'h00;
        m_last   = 1'b0;
        m_src    = 0;
    endtask

    // Priority list is ptr+1, ptr+2, ... mod N; the first requester on it wins.
    function automatic int model_pick(input logic [N-1:0] v);
        int order[$];
        for (int s = 1; s <= N; s++) order.push_back((m_ptr + s) % N);
        foreach (order[i]) begin
            if (((v >> order[i]) & 4'd1) != 4'd0) return order[i];
        end
        return -1;
    endfunction

    task automatic set_req(input logic [1:0] k, input logic [7:0] d, input logic l, input logic v);
        i_data[k*W +: W] = d;
        i_last[k]        = l;
        i_vld[k]         = v;
    endtask

    // Called just after a rising edge with inputs applied; returns just after the next rising edge.
    task automatic cycle();
        int         g;
        logic       sp;
        logic       acc;
        logic [3:0] er;
        @(negedge i_clk);
        g  = (m_locked != 0) ? m_lock : model_pick(i_vld);
        sp = !m_vld || i_rdy;
        er = (g >= 0 && sp) ? 4'(1 << g) : 4'b0000;
        seen_rdy = o_rdy;
        chk("o_rdy", 32'(o_rdy), 32'(er));
        acc = (g >= 0) && sp && (((i_vld >> g) & 4'd1) != 4'd0);
        @(posedge i_clk);
        #1;
        if (acc) begin
            m_vld  = 1'b1;
            m_data = i_data[g*W +: W];
            m_last = ((i_last >> g) & 4'd1) != 4'd0;
            m_src  = g;
            if (m_last) begin
                m_locked = 0;
                m_ptr    = g;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
        end else if (i_rdy) begin
            m_vld = 1'b0;
        end
        chk("o_vld",  32'(o_vld),  32'(m_vld));
        chk("o_data", 32'(o_data), 32'(m_data));
        chk("o_last", 32'(o_last), 32'(m_last));
        chk("o_src",  32'(o_src),  32'(m_src));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        #2;
        chk("rst_vld",  32'(o_vld),  32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_src",  32'(o_src),  32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // Every bench wait is a fixed cycle count; this only guards against a wedged simulator.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_fair[6];
        exp_fair = '{0, 1, 2, 3, 0, 1};
        i_reset = 1'b0;
        i_data  = '0;
        i_last  = '0;
        i_vld   = '0;
        i_rdy   = 1'b1;
        seen_rdy = '0;
        model_reset();
        do_reset();

        // Single requester: 3-beat packet from req1.
        set_req(2'd1, 8'h11, 1'b0, 1'b1);
        cycle();
        chk("t1_d0", 32'(o_data), 32'h11);
        chk("t1_s0", 32'(o_src), 32'd1);
        chk("t1_l0", 32'(o_last), 32'd0);
        set_req(2'd1, 8'h22, 1'b0, 1'b1);
        cycle();
        chk("t1_d1", 32'(o_data), 32'h22);
        set_req(2'd1, 8'h33, 1'b1, 1'b1);
        cycle();
        chk("t1_d2", 32'(o_data), 32'h33);
        chk("t1_l2", 32'(o_last), 32'd1);
        i_vld = '0;
        cycle();
        chk("t1_idle", 32'(o_vld), 32'd0);

        // Fairness: everyone requests single-beat packets.
        do_reset();
        i_vld  = 4'b1111;
        i_last = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fair_src", 32'(o_src), 32'(exp_fair[i]));
            chk("fair_vld", 32'(o_vld), 32'd1);
        end

        // Packet lock: req0 3-beat packet with a stall in the middle, req2 waiting.
        do_reset();
        i_vld = '0;
        set_req(2'd0, 8'hC1, 1'b0, 1'b1);
        set_req(2'd2, 8'hE1, 1'b1, 1'b1);
        cycle();
        chk("lock_s0", 32'(o_src), 32'd0);
        chk("lock_r2a", 32'(seen_rdy[2]), 32'd0);
        set_req(2'd0, 8'hC2, 1'b0, 1'b1);
        cycle();
        chk("lock_s1", 32'(o_src), 32'd0);
        chk("lock_r2b", 32'(seen_rdy[2]), 32'd0);
        set_req(2'd0, 8'hC2, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("lock_stall_r2", 32'(seen_rdy[2]), 32'd0);
            chk("lock_stall_vld", 32'(o_vld), 32'd0);
        end
        set_req(2'd0, 8'hC3, 1'b1, 1'b1);
        cycle();
        chk("lock_s2", 32'(o_src), 32'd0);
        chk("lock_l2", 32'(o_last), 32'd1);
        cycle();
        chk("lock_next", 32'(o_src), 32'd2);
        chk("lock_next_d", 32'(o_data), 32'hE1);

        // Backpressure: A5 held for 5 stalled cycles, next beat loads on release.
        do_reset();
        i_vld = '0;
        set_req(2'd1, 8'hA5, 1'b1, 1'b1);
        cycle();
        chk("bp_load", 32'(o_data), 32'hA5);
        i_rdy = 1'b0;
        set_req(2'd1, 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold", 32'(o_data), 32'hA5);
            chk("bp_rdy", 32'(seen_rdy), 32'd0);
        end
        i_rdy = 1'b1;
        cycle();
        chk("bp_rel_rdy", 32'(seen_rdy), 32'b0010);
        chk("bp_rel_d", 32'(o_data), 32'h5A);

        // Reset in the middle of req3's 4-beat packet.
        do_reset();
        i_vld = '0;
        set_req(2'd3, 8'h31, 1'b0, 1'b1);
        cycle();
        chk("mr_s0", 32'(o_src), 32'd3);
        set_req(2'd3, 8'h32, 1'b0, 1'b1);
        @(negedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        chk("mr_async_vld", 32'(o_vld), 32'd0);
        model_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_vld   = 4'b1111;
        i_last  = 4'b1111;
        cycle();
        chk("mr_first", 32'(o_src), 32'd0);

        // Pointer wrap: only req0 and req3 active.
        do_reset();
        i_vld  = 4'b1001;
        i_last = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wrap_src", 32'(o_src), (i % 2 == 0) ? 32'd0 : 32'd3);
        end

        // Random traffic with random backpressure and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            i_vld  = 4'($urandom);
            i_data = $urandom;
            for (int k = 0; k < N; k++) i_last[k] = ($urandom_range(2) == 0);
            i_rdy  = ($urandom_range(3) != 0);
            if ($urandom_range(499) == 0) do_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
